// File: rtl/door_pkg.sv
// Shared types and default timing constants for the multi-gate door blink controller.
package door_pkg;

   typedef enum logic [1:0] {
      RETRIG_IGNORE  = 2'd0,
      RETRIG_RESTART = 2'd1,
      RETRIG_QUEUE   = 2'd2
   } retrig_mode_e;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } chan_state_e;

   localparam int unsigned DEF_CLK_FREQ      = 1000;
   localparam int unsigned DEF_TOGGLE_FREQ   = 4;
   localparam int unsigned DEF_TOTAL_TOGGLES = 40;
   localparam int unsigned DEF_N_GATES       = 2;

endpackage

// File: rtl/door_blink_chan.sv
// One door blink channel: IDLE/ACTIVE FSM, half-period and toggle counters, one-deep pending request.
// Outputs are registered one cycle after req is sampled; no backpressure. Obstruction hold under DOOR_HOLD_EN.
module door_blink_chan
   import door_pkg::*;
#(
   parameter int unsigned  TOGGLE_COUNT  = DEF_CLK_FREQ / (2 * DEF_TOGGLE_FREQ),
   parameter int unsigned  TOTAL_TOGGLES = DEF_TOTAL_TOGGLES,
   parameter retrig_mode_e RETRIG        = RETRIG_IGNORE
) (
   input  logic clk,
   input  logic rst_n,
`ifdef DOOR_HOLD_EN
   input  logic hold,
`endif
   input  logic req,
   output logic door_open,
   output logic busy,
   output logic done
);

   localparam int CW = $clog2(TOGGLE_COUNT + 1);
   localparam int TW = $clog2(TOTAL_TOGGLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TOGGLE_COUNT - 1);
   localparam logic [TW-1:0] TOG_LAST = TW'(TOTAL_TOGGLES - 1);

   chan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tog_q, tog_d;
   logic          phase_q, phase_d;
   logic          open_q, open_d;
   logic          done_q, done_d;
   logic          pend_q, pend_d;
   logic          frozen;

`ifdef DOOR_HOLD_EN
   assign frozen = hold;
`else
   assign frozen = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tog_d   = tog_q;
      phase_d = phase_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ACTIVE;
               cnt_d   = '0;
               tog_d   = '0;
               phase_d = 1'b1;
            end
         end
         ACTIVE: begin
            // Restart outranks both the hold freeze and completion.
            if (req && RETRIG == RETRIG_RESTART) begin
               cnt_d   = '0;
               tog_d   = '0;
               phase_d = 1'b1;
            end else begin
               if (req && RETRIG == RETRIG_QUEUE) pend_d = 1'b1;
               if (!frozen) begin
                  if (cnt_q != CNT_LAST) begin
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     cnt_d = '0;
                     if (tog_q != TOG_LAST) begin
                        tog_d   = tog_q + 1'b1;
                        phase_d = ~phase_q;
                     end else begin
                        done_d = 1'b1;
                        tog_d  = '0;
                        // pend_d already folds in a request arriving on this very cycle.
                        if (pend_d) begin
                           pend_d  = 1'b0;
                           phase_d = 1'b1;
                        end else begin
                           state_d = IDLE;
                           phase_d = 1'b0;
                        end
                     end
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      open_d = phase_d | (frozen & (state_q == ACTIVE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tog_q   <= '0;
         phase_q <= 1'b0;
         open_q  <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tog_q   <= tog_d;
         phase_q <= phase_d;
         open_q  <= open_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
      end
   end

   assign door_open = open_q;
   assign busy      = (state_q == ACTIVE);
   assign done      = done_q;

endmodule

// File: rtl/door_blink_ctrl.sv
// N_GATES independent door blink channels, each triggered by car_in | car_out of its gate.
// One-cycle registered latency per channel; no backpressure. hold port exists only with DOOR_HOLD_EN.
module door_blink_ctrl
   import door_pkg::*;
#(
   parameter int unsigned CLK_FREQ      = DEF_CLK_FREQ,
   parameter int unsigned TOGGLE_FREQ   = DEF_TOGGLE_FREQ,
   parameter int unsigned TOGGLE_COUNT  = CLK_FREQ / (2 * TOGGLE_FREQ),
   parameter int unsigned TOTAL_TOGGLES = DEF_TOTAL_TOGGLES,
   parameter int unsigned N_GATES       = DEF_N_GATES,
   parameter int unsigned RETRIG_MODE   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_GATES-1:0] car_in,
   input  logic [N_GATES-1:0] car_out,
`ifdef DOOR_HOLD_EN
   input  logic [N_GATES-1:0] hold,
`endif
   output logic [N_GATES-1:0] door_open,
   output logic [N_GATES-1:0] busy,
   output logic [N_GATES-1:0] done
);

   localparam retrig_mode_e RETRIG = retrig_mode_e'(RETRIG_MODE[1:0]);

   logic [N_GATES-1:0] req;
   assign req = car_in | car_out;

   for (genvar i = 0; i < N_GATES; i++) begin : g_chan
      door_blink_chan #(
         .TOGGLE_COUNT (TOGGLE_COUNT),
         .TOTAL_TOGGLES(TOTAL_TOGGLES),
         .RETRIG       (RETRIG)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
`ifdef DOOR_HOLD_EN
         .hold     (hold[i]),
`endif
         .req      (req[i]),
         .door_open(door_open[i]),
         .busy     (busy[i]),
         .done     (done[i])
      );
   end

endmodule

// File: doc/door_blink_ctrl.md
Name: door_blink_ctrl

Overview:
- Multi-gate successor to the single-gate door blink block.
- Each of N_GATES channels runs its own door-open blink sequence when a car-in or car-out event occurs.
- Adds a compile-time re-trigger policy, per-channel busy and done status, and optional obstruction hold.
- Sits between the gate sensor logic and the door actuator/indicator drivers.

Parameters:
- CLK_FREQ, 1000: system clock frequency in Hz.
- TOGGLE_FREQ, 4: blink frequency in Hz.
- TOGGLE_COUNT, CLK_FREQ/(2*TOGGLE_FREQ): clock cycles per half-period; must be at least 1.
- TOTAL_TOGGLES, 40: half-periods per sequence; must be at least 1.
- N_GATES, 2: number of independent channels; must be at least 1.
- RETRIG_MODE, 0: policy for a request while busy. 0 = ignore, 1 = restart, 2 = queue one pending request.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- car_in  in  N_GATES  per-gate entry event, level-sampled.
- car_out  in  N_GATES  per-gate exit event, level-sampled.
- door_open  out  N_GATES  per-gate blink output, registered.
- busy  out  N_GATES  high while the channel's sequence is active.
- done  out  N_GATES  one-cycle pulse when a sequence completes.
- hold  in  N_GATES  obstruction hold; present only with DOOR_HOLD_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): door_open=0, busy=0, done=0, pending=0, all counters 0. Reset mid-sequence aborts it immediately.
- Per-channel request: req[i] = car_in[i] | car_out[i], sampled on each rising clk. Channels are fully independent.
- Channel state is IDLE or ACTIVE. busy equals ACTIVE.
- IDLE with req=1: next cycle ACTIVE, door_open=1, cnt=0, tog=0.
- ACTIVE counting:
  - cnt increments each cycle up to TOGGLE_COUNT-1, then wraps to 0.
  - On wrap with tog < TOTAL_TOGGLES-1: door_open inverts and tog increments.
  - On wrap with tog = TOTAL_TOGGLES-1: completion.
- Sequence length: busy stays high for exactly TOGGLE_COUNT*TOTAL_TOGGLES cycles.
- Completion, with no restart and no pending request:
  - Next cycle: IDLE, door_open=0, cnt=0, tog=0.
  - done=1 for that single cycle.
- Re-trigger (req=1 while ACTIVE):
  - Mode 0: request ignored, including on the completion cycle.
  - Mode 1: restart next cycle (door_open=1, cnt=0, tog=0, busy stays 1). Restart takes priority over completion, so no done pulse.
  - Mode 2: pending is set; further requests do not stack. At completion with pending=1: done pulses, the channel restarts next cycle with busy held at 1, and pending clears. A req on the completion cycle itself also counts as pending.
- Widths:
  - cnt is $clog2(TOGGLE_COUNT+1) bits.
  - tog is $clog2(TOTAL_TOGGLES+1) bits.
  - Counters never exceed their terminal values.
- TOTAL_TOGGLES=1: one open half-period of TOGGLE_COUNT cycles, then close. No inversion occurs.
- TOGGLE_COUNT=1: door_open changes every cycle.

Optional Feature:
- Macro: DOOR_HOLD_EN.
- With the macro defined:
  - hold port is present.
  - While ACTIVE and hold[i]=1: door_open[i] is forced to 1, cnt and tog freeze, and completion cannot occur.
  - On hold release, the sequence resumes from the frozen state and door_open reflects the saved phase on the next cycle.
  - hold has no effect in IDLE.
  - Re-trigger rules still apply while held.
- Without the macro: hold port is absent and there is no freeze logic.

Decomposition:
- Package door_pkg:
  - retrig_mode_e enum (RETRIG_IGNORE=0, RETRIG_RESTART=1, RETRIG_QUEUE=2).
  - chan_state_e enum (IDLE, ACTIVE).
  - Default frequency constants.
- Sub-module door_blink_chan: one channel holding the FSM, counters and pending flag.
- Top level: generate loop over N_GATES, plus the OR of car_in and car_out.

Test Plan (CLK_FREQ=16, TOGGLE_FREQ=2, so TOGGLE_COUNT=4; TOTAL_TOGGLES=4; N_GATES=2):
- Basic sequence: car_in[0] pulsed 1 cycle.
  - busy[0] high for 16 cycles.
  - door_open[0] pattern is 1111 0000 1111 0000, then 0.
  - done[0] pulses 1 cycle after the last half-period.
  - Channel 1 stays idle.
- Mode 0: second car_out[0] at cycle 6 of the sequence → ignored; sequence still ends after 16 cycles with one done.
- Mode 1: re-request at cycle 6 → door_open=1 at cycle 7, busy lasts 6+16 cycles, exactly one done at the end.
- Mode 2: requests at cycles 3 and 9 → two back-to-back sequences, busy high for 32 cycles continuously, done pulses at the first completion and again after the second.
- Mid-sequence reset: rst_n low at cycle 5 → outputs 0 asynchronously; no done after reset is released.
- DOOR_HOLD_EN: hold[1] high for 10 cycles starting at cycle 5 of a channel-1 sequence → door_open[1]=1 throughout the hold; busy[1] lasts 26 cycles; pattern resumes from the saved phase.
